// File: rtl/nco_pkg.sv
// Shared definitions for the NCO command path: wave codes, control-byte layout,
// status codes and the command decoder state encoding.
package nco_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] WAVE_SINE   = 2'b00;
  localparam logic [1:0] WAVE_SQUARE = 2'b01;
  localparam logic [1:0] WAVE_TRI    = 2'b10;
  localparam logic [1:0] WAVE_SAW    = 2'b11;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_WAVE_LO = 1;
  localparam int unsigned CTRL_WAVE_HI = 2;
  localparam int unsigned CTRL_FREQ    = 4;
  localparam int unsigned CTRL_DUTY    = 5;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_TRUNC   = 2'b01,
    ERR_OVERRUN = 2'b10,
    ERR_ACK     = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CTRL = 3'd1,
    ST_FREQ = 3'd2,
    ST_DUTY = 3'd3,
    ST_DONE = 3'd4,
    ST_DROP = 3'd5
  } state_e;

  // Decoded control byte; reserved bits are not kept.
  typedef struct packed {
    logic       duty;
    logic       freq;
    logic [1:0] wave;
    logic       enable;
  } ctrl_t;

endpackage

// File: rtl/nco_cmd_regfile_if.sv
// Received-byte and bus-event strobes from the I2C slave into the command decoder.
interface nco_cmd_regfile_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       bus_start;
  logic       bus_stop;
  logic       ack_error;

  modport master (output rx_valid, rx_data, bus_start, bus_stop, ack_error);
  modport slave  (input  rx_valid, rx_data, bus_start, bus_stop, ack_error);
endinterface

// File: rtl/nco_shift_word.sv
// Byte-wise MSB-first shift register with a byte counter; full_c flags that the
// word is completely loaded as of the next clock edge.
module nco_shift_word
  import nco_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] din,
  output logic [W-1:0]      word_c,
  output logic              full_c
);

  localparam int unsigned NB    = W / BYTE_W;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  logic [W-1:0]     word_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // Next word/count; shifting stops once all NB bytes are in, so the count never wraps.
  always_comb begin
    cnt_nxt = cnt_q;
    word_c  = word_q;
    if (clr) begin
      cnt_nxt = '0;
      word_c  = '0;
    end else if (shift_en && (cnt_q != CNT_W'(NB))) begin
      cnt_nxt = cnt_q + CNT_W'(1);
      word_c  = W'({word_q, din});
    end
  end

  assign full_c = (cnt_nxt == CNT_W'(NB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_nxt;
      word_q <= word_c;
    end
  end

endmodule

// File: rtl/nco_cmd_regfile.sv
// Decodes I2C write transactions into shadow registers and commits them to the
// NCO atomically, one clock after a clean STOP.
module nco_cmd_regfile
  import nco_pkg::*;
#(
  parameter int unsigned       FREQ_W   = 64,
  parameter int unsigned       DUTY_W   = 16,
  parameter logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(16'h8000)
) (
  input  logic                clk,
  input  logic                rst_n,
  nco_cmd_regfile_if.slave    rx,
  output logic                nco_enable,
  output logic [1:0]          wave,
  output logic [FREQ_W-1:0]   frequency,
  output logic [DUTY_W-1:0]   duty_cycle,
  output logic                update,
  output logic [1:0]          cmd_err
);

  state_e state_q;
  state_e state_mid;
  state_e state_nxt;

  ctrl_t ctrl_q;
  ctrl_t ctrl_rx_c;
  ctrl_t ctrl_nxt_c;

  logic              ev_ack;
  logic              ev_byte;
  logic              ev_stop;
  logic              ctrl_load;
  logic              freq_shift;
  logic              duty_shift;
  logic [FREQ_W-1:0] freq_word_c;
  logic [DUTY_W-1:0] duty_word_c;
  logic              freq_full_c;
  logic              duty_full_c;

  logic              commit_c;
  logic              freq_wr_c;
  logic              duty_wr_c;
  logic              err_wr_c;
  err_e              err_code_c;

  // START overrides everything; an ack fault overrides the byte in the same cycle.
  assign ev_ack  = !rx.bus_start && rx.ack_error;
  assign ev_byte = !rx.bus_start && !rx.ack_error && rx.rx_valid;
  assign ev_stop = !rx.bus_start && rx.bus_stop;

  assign ctrl_load  = ev_byte && (state_q == ST_CTRL);
  assign freq_shift = ev_byte && (state_q == ST_FREQ);
  assign duty_shift = ev_byte && (state_q == ST_DUTY);

  always_comb begin
    ctrl_rx_c.enable = rx.rx_data[CTRL_EN];
    ctrl_rx_c.wave   = rx.rx_data[CTRL_WAVE_HI:CTRL_WAVE_LO];
    ctrl_rx_c.freq   = rx.rx_data[CTRL_FREQ];
    ctrl_rx_c.duty   = rx.rx_data[CTRL_DUTY];
  end

  assign ctrl_nxt_c = ctrl_load ? ctrl_rx_c : ctrl_q;

  nco_shift_word #(.W(FREQ_W)) u_freq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (rx.bus_start),
    .shift_en (freq_shift),
    .din      (rx.rx_data),
    .word_c   (freq_word_c),
    .full_c   (freq_full_c)
  );

  nco_shift_word #(.W(DUTY_W)) u_duty (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (rx.bus_start),
    .shift_en (duty_shift),
    .din      (rx.rx_data),
    .word_c   (duty_word_c),
    .full_c   (duty_full_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // state_mid is the state after the byte/fault of this cycle; STOP is judged on it.
  always_comb begin
    state_mid = state_q;
    state_nxt = state_q;
    if (ev_ack) begin
      state_mid = ST_DROP;
    end else if (ev_byte) begin
      case (state_q)
        ST_CTRL: state_mid = ctrl_rx_c.freq ? ST_FREQ :
                             (ctrl_rx_c.duty ? ST_DUTY : ST_DONE);
        ST_FREQ: if (freq_full_c) state_mid = ctrl_q.duty ? ST_DUTY : ST_DONE;
        ST_DUTY: if (duty_full_c) state_mid = ST_DONE;
        ST_DONE: state_mid = ST_DROP;
        default: state_mid = state_q;
      endcase
    end
    state_nxt = state_mid;
    if (rx.bus_start) begin
      state_nxt = ST_CTRL;
    end else if (rx.bus_stop) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    commit_c   = ev_stop && (state_mid == ST_DONE);
    freq_wr_c  = commit_c && ctrl_nxt_c.freq && freq_full_c;
    duty_wr_c  = commit_c && ctrl_nxt_c.duty && duty_full_c;
    err_wr_c   = 1'b0;
    err_code_c = ERR_OK;
    if (ev_ack) begin
      err_wr_c   = 1'b1;
      err_code_c = ERR_ACK;
    end else if (ev_byte && (state_q == ST_DONE)) begin
      err_wr_c   = 1'b1;
      err_code_c = ERR_OVERRUN;
    end else if (ev_stop && ((state_mid == ST_CTRL) || (state_mid == ST_FREQ) ||
                             (state_mid == ST_DUTY))) begin
      err_wr_c   = 1'b1;
      err_code_c = ERR_TRUNC;
    end else if (commit_c) begin
      err_wr_c   = 1'b1;
      err_code_c = ERR_OK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (rx.bus_start) begin
      ctrl_q <= '0;
    end else if (ctrl_load) begin
      ctrl_q <= ctrl_rx_c;
    end
  end

  // Committed register bank; every field of a commit lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nco_enable <= 1'b0;
      wave       <= WAVE_SINE;
      frequency  <= '0;
      duty_cycle <= DUTY_RST;
      update     <= 1'b0;
      cmd_err    <= ERR_OK;
    end else begin
      update <= commit_c;
      if (commit_c) begin
        nco_enable <= ctrl_nxt_c.enable;
        wave       <= ctrl_nxt_c.wave;
      end
      if (freq_wr_c) frequency  <= freq_word_c;
      if (duty_wr_c) duty_cycle <= duty_word_c;
      if (err_wr_c)  cmd_err    <= err_code_c;
    end
  end

endmodule

// File: tb/tb_nco_cmd_regfile.sv
// Bench for nco_cmd_regfile: directed and random I2C write transactions checked
// against a transaction-level model of the register bank.
module tb_nco_cmd_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_cmd_regfile_if bus ();

  logic        nco_enable;
  logic [1:0]  wave;
  logic [63:0] frequency;
  logic [15:0] duty_cycle;
  logic        update;
  logic [1:0]  cmd_err;

  nco_cmd_regfile #(.FREQ_W(64), .DUTY_W(16), .DUTY_RST(16'h8000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (bus.slave),
    .nco_enable (nco_enable),
    .wave       (wave),
    .frequency  (frequency),
    .duty_cycle (duty_cycle),
    .update     (update),
    .cmd_err    (cmd_err)
  );

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  // Model: collect the bytes of a transaction, judge it by length at STOP.
  logic [7:0]  m_q[$];
  int          m_mode;  // 0 idle, 1 collecting, 2 dropped
  logic        m_en;
  logic [1:0]  m_wave;
  logic [63:0] m_freq;
  logic [15:0] m_duty;
  logic        m_upd;
  logic [1:0]  m_err;
  logic [7:0]  m_c;
  int          m_idx;

  function automatic int need_len(input logic [7:0] c);
    return 1 + (c[4] ? 8 : 0) + (c[5] ? 2 : 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_mode = 0; m_en = 1'b0; m_wave = 2'b00; m_freq = '0;
      m_duty = 16'h8000; m_upd = 1'b0; m_err = 2'b00;
    end else begin
      m_upd = 1'b0;
      if (bus.bus_start) begin
        m_q.delete();
        m_mode = 1;
      end else begin
        if (bus.ack_error) begin
          m_mode = 2;
          m_err  = 2'b11;
        end else if (bus.rx_valid && m_mode == 1) begin
          m_q.push_back(bus.rx_data);
          if (m_q.size() > need_len(m_q[0])) begin
            m_mode = 2;
            m_err  = 2'b10;
          end
        end
        if (bus.bus_stop) begin
          if (m_mode == 1) begin
            if (m_q.size() != 0 && m_q.size() == need_len(m_q[0])) begin
              m_c    = m_q[0];
              m_en   = m_c[0];
              m_wave = m_c[2:1];
              m_idx  = 1;
              if (m_c[4]) begin
                m_freq = '0;
                for (int k = 0; k < 8; k++) begin
                  m_freq = (m_freq << 8) | 64'(m_q[m_idx]);
                  m_idx++;
                end
              end
              if (m_c[5]) begin
                m_duty = (16'(m_q[m_idx]) << 8) | 16'(m_q[m_idx + 1]);
              end
              m_upd = 1'b1;
              m_err = 2'b00;
            end else begin
              m_err = 2'b01;
            end
          end
          m_mode = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("nco_enable", 64'(nco_enable), 64'(m_en));
      chk("wave",       64'(wave),       64'(m_wave));
      chk("frequency",  frequency,       m_freq);
      chk("duty_cycle", 64'(duty_cycle), 64'(m_duty));
      chk("update",     64'(update),     64'(m_upd));
      chk("cmd_err",    64'(cmd_err),    64'(m_err));
    end
  end

  task automatic cyc(input logic st, input logic sp, input logic rv,
                     input logic [7:0] d, input logic ae);
    @(negedge clk);
    bus.bus_start = st;
    bus.bus_stop  = sp;
    bus.rx_valid  = rv;
    bus.rx_data   = d;
    bus.ack_error = ae;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wb(input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic send_freq(input logic [63:0] f, input int nbytes);
    logic [7:0] b;
    for (int i = 7; i > 7 - nbytes; i--) begin
      b = f[i*8 +: 8];
      wb(b);
    end
  endtask

  task automatic start_();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic stop_();
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_all(input string tag, input logic en, input logic [1:0] w,
                         input logic [63:0] f, input logic [15:0] d, input logic [1:0] e);
    chk({tag, ".en"},   64'(nco_enable), 64'(en));
    chk({tag, ".wave"}, 64'(wave),       64'(w));
    chk({tag, ".freq"}, frequency,       f);
    chk({tag, ".duty"}, 64'(duty_cycle), 64'(d));
    chk({tag, ".err"},  64'(cmd_err),    64'(e));
  endtask

  logic [7:0]  r_ctrl;
  logic [7:0]  r_b;
  int          r_need, r_cnt, r_kind, r_ack_pos;
  logic        r_merge, r_stopped;

  initial begin
    bus.bus_start = 1'b0; bus.bus_stop = 1'b0; bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00; bus.ack_error = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    idle(4);
    chk_all("reset", 1'b0, 2'b00, 64'h0, 16'h8000, 2'b00);
    chk("reset.update", 64'(update), 64'h0);

    // Frequency-only write
    start_(); wb(8'h11); send_freq(64'h0001D4C0_00000000, 8); stop_();
    idle(1);
    chk("f1.update", 64'(update), 64'h1);
    chk("f1.freq_hi", 64'(frequency[63:32]), 64'h0001D4C0);
    chk_all("f1", 1'b1, 2'b00, 64'h0001D4C0_00000000, 16'h8000, 2'b00);
    idle(1);
    chk("f1.update_once", 64'(update), 64'h0);

    // Frequency and duty
    start_(); wb(8'h33); send_freq(64'h0000000A_00000000, 8); wb(8'h40); wb(8'h00); stop_();
    idle(2);
    chk_all("fd", 1'b1, 2'b01, 64'h0000000A_00000000, 16'h4000, 2'b00);

    // Truncated frequency
    start_(); wb(8'h11); send_freq(64'h1122334455667788, 3); stop_();
    idle(2);
    chk_all("trunc", 1'b1, 2'b01, 64'h0000000A_00000000, 16'h4000, 2'b01);

    // Extra byte after control-only write
    start_(); wb(8'h05); wb(8'hFF); stop_();
    idle(2);
    chk_all("overrun", 1'b1, 2'b01, 64'h0000000A_00000000, 16'h4000, 2'b10);

    // Ack fault during a frequency byte
    start_(); wb(8'h10); wb(8'hAA); wb(8'hBB);
    cyc(1'b0, 1'b0, 1'b1, 8'hCC, 1'b1); idle(1); stop_();
    idle(2);
    chk_all("ackerr", 1'b1, 2'b01, 64'h0000000A_00000000, 16'h4000, 2'b11);

    // Repeated START abandons the shadows
    start_(); wb(8'h11); send_freq(64'hDEADBEEF_01020304, 4);
    start_(); wb(8'h01); stop_();
    idle(2);
    chk_all("rstart", 1'b1, 2'b00, 64'h0000000A_00000000, 16'h4000, 2'b00);

    // Last byte coincident with STOP completes the transaction
    start_(); wb(8'h21); wb(8'h12); cyc(1'b0, 1'b1, 1'b1, 8'h34, 1'b0);
    idle(2);
    chk_all("merge", 1'b1, 2'b00, 64'h0000000A_00000000, 16'h1234, 2'b00);

    // Byte coincident with START is dropped
    cyc(1'b1, 1'b0, 1'b1, 8'h07, 1'b0); wb(8'h06); stop_();
    idle(2);
    chk_all("startwin", 1'b0, 2'b11, 64'h0000000A_00000000, 16'h1234, 2'b00);

    // Asynchronous reset in the middle of a frequency word
    start_(); wb(8'h13); send_freq(64'h55AA55AA_55AA55AA, 3); idle(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("areset", 1'b0, 2'b00, 64'h0, 16'h8000, 2'b00);
    chk("areset.update", 64'(update), 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Random transactions
    repeat (300) begin
      r_ctrl    = 8'($urandom);
      r_need    = need_len(r_ctrl);
      r_kind    = int'($urandom_range(0, 9));
      r_cnt     = r_need;
      if (r_kind == 0) r_cnt = int'($urandom_range(0, r_need - 1));
      if (r_kind == 1) r_cnt = r_need + 1;
      r_ack_pos = (r_kind == 2) ? int'($urandom_range(0, r_cnt)) : -1;
      r_merge   = ($urandom_range(0, 4) == 0);
      r_stopped = 1'b0;
      cyc(1'b1, 1'b0, 1'($urandom_range(0, 7) == 0), 8'($urandom), 1'b0);
      for (int i = 0; i < r_cnt; i++) begin
        idle(int'($urandom_range(0, 1)));
        r_b = (i == 0) ? r_ctrl : 8'($urandom);
        if (i == r_ack_pos)
          cyc(1'b0, 1'b0, 1'b1, r_b, 1'b1);
        else if (i == r_cnt - 1 && r_merge && r_kind != 3) begin
          cyc(1'b0, 1'b1, 1'b1, r_b, 1'b0);
          r_stopped = 1'b1;
        end else
          wb(r_b);
      end
      if (r_kind != 3 && !r_stopped) begin
        idle(int'($urandom_range(0, 1)));
        stop_();
      end
      if (r_kind == 4) wb(8'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
